// File: rtl/pushbutton_conditioner.sv
// pushbutton_conditioner
//   Turns four raw, bouncing pushbutton levels into clean debounced levels.
//   Each debounced press (0->1) is also captured as a sticky event for a
//   polling consumer.
//
// Ports
//   clock       in   1  rising-edge clock for all state
//   reset       in   1  asynchronous, active-high reset
//   btn_raw     in   4  raw asynchronous button levels, bit i = button i
//   rd_ack      in   1  one-cycle read strobe; clears captured events/overrun
//   pushbuttons out  4  debounced button levels
//   btn_event   out  4  sticky per-button press flags
//   event_valid out  1  OR of btn_event
//   overrun     out  1  sticky: a press landed on a still-pending event
module pushbutton_conditioner #(
  parameter int DB_CYCLES = 4,  // consecutive samples needed to accept a level (2..7)
  parameter int CW        = 3   // counter width, 2**CW > DB_CYCLES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] btn_raw,
  input  logic       rd_ack,
  output logic [3:0] pushbuttons,
  output logic [3:0] btn_event,
  output logic       event_valid,
  output logic       overrun
);

  typedef enum logic [1:0] {
    ST_LOW   = 2'd0,
    CHK_HIGH = 2'd1,
    ST_HIGH  = 2'd2,
    CHK_LOW  = 2'd3
  } state_e;

  // Terminal count: the sample that completes DB_CYCLES in a row.
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [3:0]    s1_q;
  logic [3:0]    s2_q;
  state_e        state_q [4];
  state_e        state_d [4];
  logic [CW-1:0] cnt_q   [4];
  logic [CW-1:0] cnt_d   [4];
  logic [3:0]    press_s;
  logic [3:0]    pb_d;
  logic [3:0]    pb_q;
  logic [3:0]    event_d;
  logic [3:0]    event_q;
  logic          overrun_d;
  logic          overrun_q;

  // Per-button debounce FSM next-state, counter and press detection.
  always_comb begin
    press_s = 4'b0000;
    pb_d    = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_LOW: begin
          if (s2_q[i]) begin
            state_d[i] = CHK_HIGH;
            cnt_d[i]   = CW'(1);
          end else begin
            state_d[i] = ST_LOW;
            cnt_d[i]   = '0;
          end
        end
        CHK_HIGH: begin
          if (!s2_q[i]) begin
            state_d[i] = ST_LOW;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = ST_HIGH;
            cnt_d[i]   = '0;
            press_s[i] = 1'b1;
          end else begin
            state_d[i] = CHK_HIGH;
            cnt_d[i]   = cnt_q[i] + CW'(1);
          end
        end
        ST_HIGH: begin
          if (!s2_q[i]) begin
            state_d[i] = CHK_LOW;
            cnt_d[i]   = CW'(1);
          end else begin
            state_d[i] = ST_HIGH;
            cnt_d[i]   = '0;
          end
        end
        CHK_LOW: begin
          if (s2_q[i]) begin
            state_d[i] = ST_HIGH;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = ST_LOW;
            cnt_d[i]   = '0;
          end else begin
            state_d[i] = CHK_LOW;
            cnt_d[i]   = cnt_q[i] + CW'(1);
          end
        end
        default: begin
          state_d[i] = ST_LOW;
          cnt_d[i]   = '0;
        end
      endcase
      // The debounced level stays high while a release is still being verified.
      pb_d[i] = (state_d[i] == ST_HIGH) || (state_d[i] == CHK_LOW);
    end
  end

  // Event capture: a new press wins over a simultaneous read strobe.
  // Overrun only counts presses that were not being acknowledged that cycle.
  always_comb begin
    event_d   = (rd_ack ? 4'b0000 : event_q) | press_s;
    overrun_d = (rd_ack ? 1'b0 : overrun_q) | ((|(press_s & event_q)) & ~rd_ack);
  end

  // All state registers: synchronizer, FSMs, counters and outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q      <= 4'b0000;
      s2_q      <= 4'b0000;
      pb_q      <= 4'b0000;
      event_q   <= 4'b0000;
      overrun_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= ST_LOW;
        cnt_q[i]   <= '0;
      end
    end else begin
      s1_q      <= btn_raw;
      s2_q      <= s1_q;
      pb_q      <= pb_d;
      event_q   <= event_d;
      overrun_q <= overrun_d;
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign pushbuttons = pb_q;
  assign btn_event   = event_q;
  assign event_valid = |event_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_pushbutton_conditioner.sv
// tb_pushbutton_conditioner
//   Directed, table-driven bench for pushbutton_conditioner at default
//   parameters (DB_CYCLES=4): a level stable before the first edge shows up
//   on pushbuttons after the sixth edge.
module tb_pushbutton_conditioner;

  logic       clock;
  logic       reset;
  logic [3:0] btn_raw;
  logic       rd_ack;
  logic [3:0] pushbuttons;
  logic [3:0] btn_event;
  logic       event_valid;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] btn;
    logic       ack;
    int         n;     // edges to run with these inputs before checking
    logic [3:0] pb;
    logic [3:0] ev;
    logic       ovr;
  } vec_t;

  vec_t vecs [22];

  pushbutton_conditioner dut (
    .clock       (clock),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .rd_ack      (rd_ack),
    .pushbuttons (pushbuttons),
    .btn_event   (btn_event),
    .event_valid (event_valid),
    .overrun     (overrun)
  );

  // 10-time-unit clock, first rising edge at t=5.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] pb, input logic [3:0] ev,
                           input logic ovr);
    check4({tag, " pushbuttons"}, pushbuttons, pb);
    check4({tag, " btn_event"}, btn_event, ev);
    check4({tag, " event_valid"}, {3'b000, event_valid}, {3'b000, |ev});
    check4({tag, " overrun"}, {3'b000, overrun}, {3'b000, ovr});
  endtask

  initial begin
    //             btn      ack   n   pb       ev       ovr
    vecs[0]  = '{4'b0110, 1'b0, 1, 4'b0110, 4'b0110, 1'b0}; // steady after first press
    vecs[1]  = '{4'b1010, 1'b0, 2, 4'b0110, 4'b0110, 1'b0}; // 2-cycle glitch on bits 3,2
    vecs[2]  = '{4'b0110, 1'b0, 8, 4'b0110, 4'b0110, 1'b0}; // glitch rejected
    vecs[3]  = '{4'b0110, 1'b1, 1, 4'b0110, 4'b0000, 1'b0}; // read clears events
    vecs[4]  = '{4'b0110, 1'b1, 1, 4'b0110, 4'b0000, 1'b0}; // read with nothing pending
    vecs[5]  = '{4'b0100, 1'b0, 6, 4'b0100, 4'b0000, 1'b0}; // release bit 1, no event
    vecs[6]  = '{4'b0110, 1'b0, 5, 4'b0100, 4'b0000, 1'b0}; // repress, one edge short
    vecs[7]  = '{4'b0110, 1'b0, 1, 4'b0110, 4'b0010, 1'b0}; // accepted on 6th edge
    vecs[8]  = '{4'b0100, 1'b0, 6, 4'b0100, 4'b0010, 1'b0}; // release keeps event
    vecs[9]  = '{4'b0110, 1'b0, 6, 4'b0110, 4'b0010, 1'b1}; // press on pending -> overrun
    vecs[10] = '{4'b0110, 1'b1, 1, 4'b0110, 4'b0000, 1'b0}; // read clears both
    vecs[11] = '{4'b0100, 1'b0, 6, 4'b0100, 4'b0000, 1'b0};
    vecs[12] = '{4'b0110, 1'b0, 6, 4'b0110, 4'b0010, 1'b0}; // bit 1 pending
    vecs[13] = '{4'b1110, 1'b0, 5, 4'b0110, 4'b0010, 1'b0}; // bit 3 one edge short
    vecs[14] = '{4'b1110, 1'b1, 1, 4'b1110, 4'b1000, 1'b0}; // read on acceptance edge
    vecs[15] = '{4'b1110, 1'b0, 1, 4'b1110, 4'b1000, 1'b0};
    vecs[16] = '{4'b0000, 1'b0, 5, 4'b1110, 4'b1000, 1'b0}; // release, one edge short
    vecs[17] = '{4'b0000, 1'b0, 1, 4'b0000, 4'b1000, 1'b0}; // release after 6 edges
    vecs[18] = '{4'b0000, 1'b1, 1, 4'b0000, 4'b0000, 1'b0};
    vecs[19] = '{4'b0011, 1'b0, 6, 4'b0011, 4'b0011, 1'b0}; // simultaneous presses
    vecs[20] = '{4'b0000, 1'b0, 6, 4'b0000, 4'b0011, 1'b0}; // release 0011
    vecs[21] = '{4'b0000, 1'b1, 1, 4'b0000, 4'b0000, 1'b0};

    // Reset pulse at t=2..3 with 0110 already held.
    btn_raw = 4'b0110;
    rd_ack  = 1'b0;
    reset   = 1'b0;
    #2 reset = 1'b1;
    #0.5;
    check_all("in_reset", 4'b0000, 4'b0000, 1'b0);
    #0.5 reset = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check_all("edge5", 4'b0000, 4'b0000, 1'b0);
    @(posedge clock);
    #1;
    check_all("edge6", 4'b0110, 4'b0110, 1'b0);

    for (int r = 0; r < 22; r++) begin
      btn_raw = vecs[r].btn;
      rd_ack  = vecs[r].ack;
      repeat (vecs[r].n) @(posedge clock);
      #1;
      rd_ack = 1'b0;
      check_all($sformatf("row%0d", r), vecs[r].pb, vecs[r].ev, vecs[r].ovr);
    end

    // Press everything, then an asynchronous reset mid-cycle while 0011
    // is being held must clear outputs at once and restart the full latency.
    btn_raw = 4'b1111;
    repeat (6) @(posedge clock);
    #1;
    check_all("all_held", 4'b1111, 4'b1111, 1'b0);
    btn_raw = 4'b0011;
    repeat (3) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check_all("async_reset", 4'b0000, 4'b0000, 1'b0);
    #2 reset = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check_all("post_reset5", 4'b0000, 4'b0000, 1'b0);
    @(posedge clock);
    #1;
    check_all("post_reset6", 4'b0011, 4'b0011, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
